// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA frame reader: 640x480@60 timing,
// cell geometry and the bit layout of a frame-buffer word.
package vga_pkg;

    typedef logic [9:0] cnt_t;

    localparam int VGA_CLK_DIV  = 2;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    localparam int VGA_CELL_W    = 40;
    localparam int VGA_CELL_H    = 40;
    localparam int VGA_COLS      = VGA_H_ACTIVE / VGA_CELL_W;
    localparam int VGA_BASE_ADDR = 0;

    localparam int VGA_R_MSB = 23;
    localparam int VGA_R_LSB = 16;
    localparam int VGA_G_MSB = 15;
    localparam int VGA_G_LSB = 8;
    localparam int VGA_B_MSB = 7;
    localparam int VGA_B_LSB = 0;

    function automatic bit is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// Video read port plus the registered pixel/sync outputs of the frame reader.
interface vga_frame_reader_if;
    logic [31:0] av;
    logic [31:0] Rdv;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        frame_start;

    modport master (output av, hsync, vsync, de, r, g, b, frame_start, input Rdv);
    modport slave  (input av, hsync, vsync, de, r, g, b, frame_start, output Rdv);
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel divider and raster counters; sync/active flags describe the current
// (stage-1) raster position, frame_start marks the tick at (0,0).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic tick_o,
    output logic h_last_o,
    output logic v_last_o,
    output logic active_o,
    output logic hsync_n_o,
    output logic vsync_n_o,
    output logic frame_start_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SS    = H_ACTIVE + H_FP;
    localparam int H_SE    = H_SS + H_SYNC - 1;
    localparam int V_SS    = V_ACTIVE + V_FP;
    localparam int V_SE    = V_SS + V_SYNC - 1;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    cnt_t             hcnt_q, hcnt_d;
    cnt_t             vcnt_q, vcnt_d;
    logic             tick;

    assign h_last_o = (hcnt_q == cnt_t'(H_TOTAL - 1));
    assign v_last_o = (vcnt_q == cnt_t'(V_TOTAL - 1));

    always_comb begin
        tick   = (div_q == DIV_W'(CLK_DIV - 1));
        div_d  = tick ? '0 : div_q + 1'b1;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (tick) begin
            if (h_last_o) begin
                hcnt_d = '0;
                vcnt_d = v_last_o ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q  <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            div_q  <= div_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign tick_o        = tick;
    assign active_o      = (hcnt_q < cnt_t'(H_ACTIVE)) && (vcnt_q < cnt_t'(V_ACTIVE));
    assign hsync_n_o     = !((hcnt_q >= cnt_t'(H_SS)) && (hcnt_q <= cnt_t'(H_SE)));
    assign vsync_n_o     = !((vcnt_q >= cnt_t'(V_SS)) && (vcnt_q <= cnt_t'(V_SE)));
    assign frame_start_o = tick && (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: rtl/vga_frame_reader.sv
// Scans a cell-mapped frame buffer over the memory video port and emits RGB888 + syncs.
// Build option VGA_GRID_EN overlays a 1-pixel white grid on cell borders.
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = VGA_CLK_DIV,
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int CELL_W    = VGA_CELL_W,
    parameter int CELL_H    = VGA_CELL_H,
    parameter int COLS      = H_ACTIVE / CELL_W,
    parameter int BASE_ADDR = VGA_BASE_ADDR
) (
    input  logic               CLK,
    input  logic               RST_n,
    vga_frame_reader_if.master vid
);
    logic tick, h_last, v_last, active, hsync_n, vsync_n, frame_start;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk_i        (CLK),
        .rst_n_i      (RST_n),
        .tick_o       (tick),
        .h_last_o     (h_last),
        .v_last_o     (v_last),
        .active_o     (active),
        .hsync_n_o    (hsync_n),
        .vsync_n_o    (vsync_n),
        .frame_start_o(frame_start)
    );

    cnt_t        px_q, px_d, col_q, col_d;
    cnt_t        ln_q, ln_d, row_q, row_d;
    logic [31:0] row_base;
    logic [31:0] av_q, av_d;
    logic        act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic [23:0] rgb_q, rgb_d, rdv_rgb, pix_word;
    logic        unused_rdv;

    assign rdv_rgb    = {vid.Rdv[VGA_R_MSB:VGA_R_LSB], vid.Rdv[VGA_G_MSB:VGA_G_LSB],
                         vid.Rdv[VGA_B_MSB:VGA_B_LSB]};
    assign unused_rdv = ^vid.Rdv[31:24];

    // row*COLS: a plain shift for power-of-two widths, else a per-row accumulator
    if (is_pow2(COLS)) begin : g_shift
        assign row_base = 32'(row_q) << $clog2(COLS);
    end else begin : g_accum
        logic [31:0] rb_q, rb_d;
        always_comb begin
            rb_d = rb_q;
            if (tick && h_last) begin
                if (v_last) begin
                    rb_d = '0;
                end else if (ln_q == cnt_t'(CELL_H - 1)) begin
                    rb_d = rb_q + 32'(COLS);
                end
            end
        end
        always_ff @(posedge CLK or negedge RST_n) begin
            if (!RST_n) rb_q <= '0;
            else        rb_q <= rb_d;
        end
        assign row_base = rb_q;
    end

`ifdef VGA_GRID_EN
    logic grid1_q, grid1_d;
    assign pix_word = grid1_q ? 24'hFF_FFFF : rdv_rgb;
`else
    assign pix_word = rdv_rgb;
`endif

    always_comb begin
        px_d    = px_q;
        col_d   = col_q;
        ln_d    = ln_q;
        row_d   = row_q;
        av_d    = av_q;
        act1_d  = act1_q;
        hs1_d   = hs1_q;
        vs1_d   = vs1_q;
        de_d    = de_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        rgb_d   = rgb_q;
`ifdef VGA_GRID_EN
        grid1_d = grid1_q;
`endif
        if (tick) begin
            if (h_last) begin
                px_d  = '0;
                col_d = '0;
                if (v_last) begin
                    ln_d  = '0;
                    row_d = '0;
                end else if (ln_q == cnt_t'(CELL_H - 1)) begin
                    ln_d  = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    ln_d  = ln_q + 1'b1;
                end
            end else if (px_q == cnt_t'(CELL_W - 1)) begin
                px_d  = '0;
                col_d = col_q + 1'b1;
            end else begin
                px_d  = px_q + 1'b1;
            end

            // stage 1: address of the current pixel; held through blanking
            if (active) av_d = 32'(BASE_ADDR) + row_base + 32'(col_q);
            act1_d = active;
            hs1_d  = hsync_n;
            vs1_d  = vsync_n;
`ifdef VGA_GRID_EN
            grid1_d = (px_q == '0) || (ln_q == '0);
`endif
            // stage 2: read data for the previous tick's address
            de_d    = act1_q;
            hsync_d = hs1_q;
            vsync_d = vs1_q;
            rgb_d   = act1_q ? pix_word : '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            px_q    <= '0;
            col_q   <= '0;
            ln_q    <= '0;
            row_q   <= '0;
            av_q    <= 32'(BASE_ADDR);
            act1_q  <= 1'b0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            de_q    <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
`ifdef VGA_GRID_EN
            grid1_q <= 1'b0;
`endif
        end else begin
            px_q    <= px_d;
            col_q   <= col_d;
            ln_q    <= ln_d;
            row_q   <= row_d;
            av_q    <= av_d;
            act1_q  <= act1_d;
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
`ifdef VGA_GRID_EN
            grid1_q <= grid1_d;
`endif
        end
    end

    assign vid.av          = av_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.r           = rgb_q[23:16];
    assign vid.g           = rgb_q[15:8];
    assign vid.b           = rgb_q[7:0];
    assign vid.frame_start = frame_start;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Randomized frame-buffer bench for vga_frame_reader on a reduced raster geometry.
module tb_vga_frame_reader;
    localparam int DIV = 2;
    localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
    localparam int VA = 48, VFP = 2, VSW = 2, VBP = 3;
    localparam int CW = 8, CH = 8, NCOL = HA / CW, BASE = 4;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME_CLK = HT * VT * DIV;
    localparam int COLOUR_ADDR = 13;
    localparam logic [31:0] COLOUR_WORD = 32'hAA12_3456;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic [31:0] mem [256];
    int          n_checks = 0;
    int          n_err = 0;

    vga_frame_reader_if vid();
    assign vid.Rdv = mem[vid.av[7:0]];

    vga_frame_reader #(
        .CLK_DIV(DIV),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .CELL_W(CW), .CELL_H(CH), .COLS(NCOL), .BASE_ADDR(BASE)
    ) dut (
        .CLK  (CLK),
        .RST_n(RST_n),
        .vid  (vid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_active(input int h, input int v);
        return (h < HA) && (v < VA);
    endfunction

    function automatic int cell_addr(input int h, input int v);
        return BASE + (v / CH) * NCOL + h / CW;
    endfunction

    function automatic bit hs_low(input int h);
        return (h >= HA + HFP) && (h < HA + HFP + HSW);
    endfunction

    function automatic bit vs_low(input int v);
        return (v >= VA + VFP) && (v < VA + VFP + VSW);
    endfunction

    function automatic logic [31:0] rgb_now();
        return {8'h00, vid.r, vid.g, vid.b};
    endfunction

    // Reference model: p posedges since reset release, k = completed pixel ticks.
    // Tick j reads raster position j; outputs after k ticks show position k-2.
    int          p, k, ph, hq, vq;
    logic [31:0] last_av, cap_next, cap_cur;
    logic        exp_de, exp_hs, exp_vs, exp_fs;
    logic [23:0] exp_rgb;

    always @(negedge CLK) begin
        if (!RST_n) begin
            chk("rst_av", vid.av, BASE);
            chk("rst_hsync", vid.hsync, 1);
            chk("rst_vsync", vid.vsync, 1);
            chk("rst_de", vid.de, 0);
            chk("rst_rgb", rgb_now(), 0);
            chk("rst_frame_start", vid.frame_start, 0);
            p = 0;
            last_av = BASE;
            cap_next = '0;
            cap_cur = '0;
        end else begin
            p++;
            k = p / DIV;
            ph = p % DIV;
            if (ph == 0) begin
                hq = (k - 1) % HT;
                vq = ((k - 1) / HT) % VT;
                if (in_active(hq, vq)) last_av = cell_addr(hq, vq);
                cap_cur = cap_next;
            end
            exp_fs = (ph == DIV - 1) && (k % (HT * VT) == 0);
            exp_de = 1'b0;
            exp_hs = 1'b1;
            exp_vs = 1'b1;
            exp_rgb = '0;
            if (k >= 2) begin
                hq = (k - 2) % HT;
                vq = ((k - 2) / HT) % VT;
                exp_de = in_active(hq, vq);
                exp_hs = !hs_low(hq);
                exp_vs = !vs_low(vq);
                if (exp_de) begin
`ifdef VGA_GRID_EN
                    exp_rgb = ((hq % CW == 0) || (vq % CH == 0)) ? 24'hFF_FFFF : cap_cur[23:0];
`else
                    exp_rgb = cap_cur[23:0];
`endif
                end
            end
            chk("av", vid.av, last_av);
            chk("de", vid.de, exp_de);
            chk("hsync", vid.hsync, exp_hs);
            chk("vsync", vid.vsync, exp_vs);
            chk("rgb", rgb_now(), {8'h00, exp_rgb});
            chk("frame_start", vid.frame_start, exp_fs);
            if (ph == 0) begin
                case (k)
                    1:    chk("lit_av_first", vid.av, 32'd4);
                    72: begin
                        chk("lit_hsync_low", vid.hsync, 0);
                        chk("lit_rgb_blank", rgb_now(), 0);
                    end
                    75:   chk("lit_av_hold_blank", vid.av, 32'd11);
                    641:  chk("lit_av_row1", vid.av, 32'd12);
                    734:  chk("lit_av_cell13", vid.av, 32'd13);
                    735: begin
                        chk("lit_rgb_cell13", rgb_now(), 32'h0012_3456);
                        chk("lit_de_cell13", vid.de, 1);
                    end
                    3824: chk("lit_av_last", vid.av, 32'd51);
                    3992: chk("lit_vsync_high", vid.vsync, 1);
                    4002: chk("lit_vsync_low", vid.vsync, 0);
`ifdef VGA_GRID_EN
                    170:  chk("lit_grid_col", rgb_now(), 32'h00FF_FFFF);
                    1284: chk("lit_grid_row", rgb_now(), 32'h00FF_FFFF);
`endif
                    default: ;
                endcase
            end
            if (ph == DIV - 1) cap_next = mem[last_av[7:0]];
        end
    end

    // Interval measurements of the output waveforms.
    longint cyc = 0, fs_last = 0;
    int     since_rel, de_run, hs_run, vs_run, since_fall, n_fs = 0;
    bit     de_fell, fs_have;
    logic   de_p, hs_p, vs_p;

    always @(negedge CLK) begin
        cyc++;
        if (!RST_n) begin
            since_rel = 0;
            de_run = 0;
            hs_run = 0;
            vs_run = 0;
            since_fall = 0;
            de_fell = 0;
            fs_have = 0;
            de_p = 0;
            hs_p = 1;
            vs_p = 1;
        end else begin
            since_rel++;
            since_fall++;
            if (vid.de) begin
                de_run++;
            end else if (de_p) begin
                chk("de_width_clk", de_run, HA * DIV);
                de_run = 0;
                de_fell = 1;
                since_fall = 0;
            end
            if (!vid.hsync) begin
                if (hs_p && de_fell) begin
                    chk("hsync_after_de_clk", since_fall, HFP * DIV);
                    de_fell = 0;
                end
                hs_run++;
            end else if (!hs_p) begin
                chk("hsync_width_clk", hs_run, HSW * DIV);
                hs_run = 0;
            end
            if (!vid.vsync) begin
                vs_run++;
            end else if (!vs_p) begin
                chk("vsync_width_clk", vs_run, VSW * HT * DIV);
                vs_run = 0;
            end
            if (vid.frame_start) begin
                n_fs++;
                if (fs_have) chk("frame_period_clk", 32'(cyc - fs_last), FRAME_CLK);
                else         chk("first_frame_start_clk", since_rel, 1);
                fs_have = 1;
                fs_last = cyc;
            end
            de_p = vid.de;
            hs_p = vid.hsync;
            vs_p = vid.vsync;
        end
    end

    // Background CPU-style writes, including mid-frame, away from the pinned cell.
    int wa;
    initial begin
        forever begin
            @(posedge CLK);
            #3;
            if (RST_n && ($urandom_range(0, 7) == 0)) begin
                wa = $urandom_range(0, 255);
                if (wa != COLOUR_ADDR) mem[wa] = $urandom;
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[COLOUR_ADDR] = COLOUR_WORD;
        RST_n = 1'b0;
        repeat (5) @(negedge CLK);
        #1 RST_n = 1'b1;

        repeat (2 * FRAME_CLK + 30 * HT * DIV) @(negedge CLK);

        @(posedge CLK);
        #2 RST_n = 1'b0;
        #1;
        chk("async_rst_av", vid.av, BASE);
        chk("async_rst_hsync", vid.hsync, 1);
        chk("async_rst_vsync", vid.vsync, 1);
        chk("async_rst_de", vid.de, 0);
        chk("async_rst_rgb", rgb_now(), 0);
        chk("async_rst_frame_start", vid.frame_start, 0);
        repeat (5) @(negedge CLK);
        #1 RST_n = 1'b1;

        repeat (FRAME_CLK + 3000) @(negedge CLK);
        chk("frame_start_count", n_fs, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
